// File: rtl/otp_auth_ctrl.sv
// OTP authentication controller: captures a generated OTP, collects DIGITS user digits, compares,
// with session timeout, attempt limit and timed lockout. Optional backspace via OTP_BACKSPACE_EN.
module otp_auth_ctrl #(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int ENTRY_TIMEOUT  = 1_500_000_000,
    parameter int HOLD_CYCLES    = 250_000_000,
    parameter int LOCKOUT_CYCLES = 500_000_000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DIGITS*DIGIT_W-1:0]         otp_in,
    input  logic                              otp_valid,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_valid,
    input  logic                              digit_clear,
    output logic [DIGITS*DIGIT_W-1:0]         otp,
    output logic [DIGITS*DIGIT_W-1:0]         user_otp,
    output logic [$clog2(DIGITS+1)-1:0]       digit_cnt,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] wrng_atmpt,
    output logic                              unlock,
    output logic                              expired,
    output logic                              locked_out,
    output logic                              fail_pulse,
    output logic [2:0]                        state
);

    localparam int OTP_W    = DIGITS * DIGIT_W;
    localparam int CNT_W    = $clog2(DIGITS + 1);
    localparam int ATT_W    = $clog2(MAX_ATTEMPTS + 1);
    localparam int SES_W    = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
    localparam int HOLD_MAX = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int HLD_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_ENTER    = 3'd2,
        S_CHECK    = 3'd3,
        S_UNLOCKED = 3'd4,
        S_EXPIRED  = 3'd5,
        S_LOCKOUT  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [OTP_W-1:0]   otp_q, otp_d;
    logic [OTP_W-1:0]   user_otp_q, user_otp_d;
    logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
    logic [ATT_W-1:0]   wrng_q, wrng_d;
    logic [SES_W-1:0]   ses_q, ses_d;
    logic [HLD_W-1:0]   hold_q, hold_d;
    logic               unlock_q, expired_q, locked_q, fail_q, fail_d;

`ifndef OTP_BACKSPACE_EN
    logic unused_digit_clear;
    assign unused_digit_clear = digit_clear;
`endif

    always_comb begin
        state_d     = state_q;
        otp_d       = otp_q;
        user_otp_d  = user_otp_q;
        digit_cnt_d = digit_cnt_q;
        wrng_d      = wrng_q;
        ses_d       = ses_q;
        hold_d      = hold_q;
        fail_d      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_GEN;
            S_GEN: begin
                if (otp_valid) begin
                    otp_d   = otp_in;
                    ses_d   = '0;
                    state_d = S_ENTER;
                end
            end
            S_ENTER: begin
                ses_d = ses_q + SES_W'(1);
                // Timeout has priority: a digit arriving in the expiry cycle is dropped.
                if (ses_q == SES_W'(ENTRY_TIMEOUT - 1)) begin
                    ses_d   = '0;
                    state_d = S_EXPIRED;
`ifdef OTP_BACKSPACE_EN
                end else if (digit_clear) begin
                    if (digit_cnt_q != '0) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (digit_cnt_q == CNT_W'(i + 1))
                                user_otp_d[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = '0;
                        end
                        digit_cnt_d = digit_cnt_q - CNT_W'(1);
                    end
`endif
                end else if (digit_valid) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (digit_cnt_q == CNT_W'(i))
                            user_otp_d[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
                    end
                    digit_cnt_d = digit_cnt_q + CNT_W'(1);
                    if (digit_cnt_q == CNT_W'(DIGITS - 1))
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (otp_q == user_otp_q) begin
                    state_d = S_UNLOCKED;
                end else begin
                    fail_d      = 1'b1;
                    wrng_d      = wrng_q + ATT_W'(1);
                    user_otp_d  = '0;
                    digit_cnt_d = '0;
                    state_d     = (wrng_d == ATT_W'(MAX_ATTEMPTS)) ? S_LOCKOUT : S_ENTER;
                end
            end
            S_UNLOCKED, S_EXPIRED: begin
                if (hold_q == HLD_W'(HOLD_CYCLES - 1)) state_d = S_IDLE;
                else                                    hold_d  = hold_q + HLD_W'(1);
            end
            S_LOCKOUT: begin
                if (hold_q == HLD_W'(LOCKOUT_CYCLES - 1)) state_d = S_IDLE;
                else                                       hold_d  = hold_q + HLD_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Everything is wiped on entry to IDLE so IDLE itself presents all-zero outputs.
        if (state_d == S_IDLE) begin
            otp_d       = '0;
            user_otp_d  = '0;
            digit_cnt_d = '0;
            wrng_d      = '0;
            ses_d       = '0;
            hold_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            otp_q       <= '0;
            user_otp_q  <= '0;
            digit_cnt_q <= '0;
            wrng_q      <= '0;
            ses_q       <= '0;
            hold_q      <= '0;
            unlock_q    <= 1'b0;
            expired_q   <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            otp_q       <= otp_d;
            user_otp_q  <= user_otp_d;
            digit_cnt_q <= digit_cnt_d;
            wrng_q      <= wrng_d;
            ses_q       <= ses_d;
            hold_q      <= hold_d;
            unlock_q    <= (state_d == S_UNLOCKED);
            expired_q   <= (state_d == S_EXPIRED);
            locked_q    <= (state_d == S_LOCKOUT);
            fail_q      <= fail_d;
        end
    end

    assign otp        = otp_q;
    assign user_otp   = user_otp_q;
    assign digit_cnt  = digit_cnt_q;
    assign wrng_atmpt = wrng_q;
    assign unlock     = unlock_q;
    assign expired    = expired_q;
    assign locked_out = locked_q;
    assign fail_pulse = fail_q;
    assign state      = state_q;

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Self-checking bench for otp_auth_ctrl: table of OTP/entry vectors plus directed sequences for
// hold timing, lockout, timeout, input gating, backspace (when OTP_BACKSPACE_EN) and async reset.
module tb_otp_auth_ctrl;

    localparam int DIGITS         = 4;
    localparam int DIGIT_W        = 4;
    localparam int MAX_ATTEMPTS   = 3;
    localparam int ENTRY_TIMEOUT  = 100;
    localparam int HOLD_CYCLES    = 10;
    localparam int LOCKOUT_CYCLES = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] otp_in;
    logic        otp_valid;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        digit_clear;
    logic [15:0] otp;
    logic [15:0] user_otp;
    logic [2:0]  digit_cnt;
    logic [1:0]  wrng_atmpt;
    logic        unlock, expired, locked_out, fail_pulse;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    otp_auth_ctrl #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_ATTEMPTS(MAX_ATTEMPTS),
        .ENTRY_TIMEOUT(ENTRY_TIMEOUT), .HOLD_CYCLES(HOLD_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .otp_in(otp_in), .otp_valid(otp_valid),
        .digit_in(digit_in), .digit_valid(digit_valid), .digit_clear(digit_clear),
        .otp(otp), .user_otp(user_otp), .digit_cnt(digit_cnt), .wrng_atmpt(wrng_atmpt),
        .unlock(unlock), .expired(expired), .locked_out(locked_out),
        .fail_pulse(fail_pulse), .state(state)
    );

    typedef struct {
        logic [15:0] otp_val;
        logic [15:0] entry;
        logic        exp_unlock;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        otp_valid   = 1'b0;
        digit_valid = 1'b0;
        digit_clear = 1'b0;
        reset       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_otp", 32'(otp), 32'd0);
        check("rst_user_otp", 32'(user_otp), 32'd0);
        check("rst_misc", 32'({digit_cnt, wrng_atmpt, unlock, expired, locked_out, fail_pulse}), 32'd0);
        reset = 1'b1;
    endtask

    task automatic start_session(input logic [15:0] v);
        step();
        check("gen_state", 32'(state), 32'd1);
        otp_in    = v;
        otp_valid = 1'b1;
        step();
        otp_valid = 1'b0;
        check("enter_state", 32'(state), 32'd2);
        check("otp_capture", 32'(otp), 32'(v));
    endtask

    task automatic enter_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic clear_digit();
        digit_clear = 1'b1;
        step();
        digit_clear = 1'b0;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return unlock;
            1:       return expired;
            default: return locked_out;
        endcase
    endfunction

    task automatic count_high(input int which, output int n);
        n = 0;
        while (sel(which) && n < 200) begin
            n++;
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [15:0] w;
        otp_in      = '0;
        digit_in    = '0;
        otp_valid   = 1'b0;
        digit_valid = 1'b0;
        digit_clear = 1'b0;
        reset       = 1'b0;

        vecs[0] = '{16'h3A7C, 16'h3A7C, 1'b1};
        vecs[1] = '{16'h1234, 16'h1235, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b0};
        vecs[5] = '{16'h8001, 16'h0001, 1'b0};
        vecs[6] = '{16'h1234, 16'h4321, 1'b0};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            start_session(vecs[v].otp_val);
            w = vecs[v].entry;
            for (int i = 0; i < 4; i++) begin
                enter_digit(w[15-4*i -: 4]);
                check("vec_digit_cnt", 32'(digit_cnt), 32'(i + 1));
            end
            check("vec_check_state", 32'(state), 32'd3);
            check("vec_user_otp", 32'(user_otp), 32'(w));
            step();
            if (vecs[v].exp_unlock) begin
                check("vec_unlock", 32'(unlock), 32'd1);
                check("vec_unlocked_state", 32'(state), 32'd4);
                check("vec_no_fail", 32'(fail_pulse), 32'd0);
            end else begin
                check("vec_fail_pulse", 32'(fail_pulse), 32'd1);
                check("vec_wrng", 32'(wrng_atmpt), 32'd1);
                check("vec_cnt_cleared", 32'(digit_cnt), 32'd0);
                check("vec_user_cleared", 32'(user_otp), 32'd0);
                check("vec_back_to_enter", 32'(state), 32'd2);
                check("vec_no_unlock", 32'(unlock), 32'd0);
            end
            $display("vec %0d otp=%h entry=%h unlock=%0b wrng=%0d", v, vecs[v].otp_val, w, unlock, wrng_atmpt);
        end

        // Input gating, then unlock hold length.
        do_reset();
        step();
        digit_in    = 4'h3;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        check("gen_ignores_digit_state", 32'(state), 32'd1);
        check("gen_ignores_digit_cnt", 32'(digit_cnt), 32'd0);
        otp_in    = 16'h3A7C;
        otp_valid = 1'b1;
        step();
        otp_in      = 16'hFFFF;
        digit_in    = 4'h3;
        digit_valid = 1'b1;
        step();
        otp_valid   = 1'b0;
        digit_valid = 1'b0;
        check("enter_ignores_otp_valid", 32'(otp), 32'h3A7C);
        check("enter_digit_with_otp_valid", 32'(digit_cnt), 32'd1);
        enter_digit(4'hA);
        enter_digit(4'h7);
        enter_digit(4'hC);
        check("hold_check_state", 32'(state), 32'd3);
        step();
        count_high(0, n);
        check("unlock_cycles", 32'(n), 32'(HOLD_CYCLES));
        check("unlock_then_idle", 32'(state), 32'd0);
        check("unlock_idle_otp", 32'(otp), 32'd0);
        $display("seq hold: unlock high for %0d cycles", n);

        // Three wrong entries -> lockout.
        do_reset();
        start_session(16'h1234);
        for (int a = 0; a < 3; a++) begin
            enter_digit(4'h1);
            enter_digit(4'h2);
            enter_digit(4'h3);
            enter_digit(4'h5);
            check("lock_check_state", 32'(state), 32'd3);
            step();
            check("lock_fail_pulse", 32'(fail_pulse), 32'd1);
            check("lock_wrng", 32'(wrng_atmpt), 32'(a + 1));
            if (a == 0) begin
                step();
                check("fail_pulse_one_cycle", 32'(fail_pulse), 32'd0);
                check("retry_state", 32'(state), 32'd2);
            end
        end
        check("lockout_state", 32'(state), 32'd6);
        check("lockout_flag", 32'(locked_out), 32'd1);
        count_high(2, n);
        check("lockout_cycles", 32'(n), 32'(LOCKOUT_CYCLES));
        check("lockout_idle_state", 32'(state), 32'd0);
        check("lockout_idle_outputs",
              32'({otp, digit_cnt, wrng_atmpt, unlock, expired, locked_out, fail_pulse}), 32'd0);
        check("lockout_idle_user", 32'(user_otp), 32'd0);
        $display("seq lockout: locked_out high for %0d cycles", n);

        // Session timeout with a digit arriving in the expiry cycle.
        do_reset();
        start_session(16'h5555);
        repeat (ENTRY_TIMEOUT - 1) step();
        check("timeout_last_enter", 32'(state), 32'd2);
        digit_in    = 4'h5;
        digit_valid = 1'b1;
        step();
        digit_valid = 1'b0;
        check("timeout_state", 32'(state), 32'd5);
        check("timeout_expired", 32'(expired), 32'd1);
        check("timeout_digit_dropped", 32'(digit_cnt), 32'd0);
        check("timeout_user_otp", 32'(user_otp), 32'd0);
        count_high(1, n);
        check("expired_cycles", 32'(n), 32'(HOLD_CYCLES));
        check("expired_idle_state", 32'(state), 32'd0);
        $display("seq timeout: expired high for %0d cycles", n);

        // digit_clear handling.
        do_reset();
        start_session(16'h1234);
`ifdef OTP_BACKSPACE_EN
        clear_digit();
        check("bs_clear_at_zero", 32'(digit_cnt), 32'd0);
        enter_digit(4'h1);
        enter_digit(4'h9);
        check("bs_before_clear", 32'(user_otp), 32'h1900);
        clear_digit();
        check("bs_cnt_after_clear", 32'(digit_cnt), 32'd1);
        check("bs_user_after_clear", 32'(user_otp), 32'h1000);
`else
        enter_digit(4'h1);
        clear_digit();
        check("noclr_cnt", 32'(digit_cnt), 32'd1);
        check("noclr_user", 32'(user_otp), 32'h1000);
`endif
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h4);
        check("clr_check_state", 32'(state), 32'd3);
        step();
        check("clr_unlock", 32'(unlock), 32'd1);
        $display("seq clear: unlock=%0b", unlock);

        // Asynchronous reset while unlocked.
        do_reset();
        start_session(16'h3A7C);
        enter_digit(4'h3);
        enter_digit(4'hA);
        enter_digit(4'h7);
        enter_digit(4'hC);
        step();
        step();
        check("pre_areset_unlock", 32'(unlock), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("areset_unlock", 32'(unlock), 32'd0);
        check("areset_otp", 32'(otp), 32'd0);
        check("areset_user_otp", 32'(user_otp), 32'd0);
        check("areset_state", 32'(state), 32'd0);
        $display("seq async reset: state=%0d unlock=%0b", state, unlock);
        step();
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
